// File: rtl/divider.sv
// divider: multi-cycle radix-2 restoring divide/remainder unit for RV32M DIV/DIVU/REM/REMU.
// Optional macro DIVIDER_EARLY_OUT_EN: divide-by-zero, overflow and |a|<|b| finish on the request edge.
module divider #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk_n,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_in_a,
  input  logic [WIDTH-1:0] i_in_b,
  input  logic [2:0]       i_funct3,
  input  logic             i_div_en,
  input  logic             i_pipe_adv,
  output logic [WIDTH-1:0] o_result,
  output logic             o_busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             rem_sel_q, rem_sel_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic is_signed);
    logic signed [WIDTH-1:0] s;
    s = signed'(x);
    return (is_signed && s < 0) ? -s : s;
  endfunction

  function automatic logic [WIDTH-1:0] sign_fix(input logic [WIDTH-1:0] mag, input logic neg);
    logic signed [WIDTH-1:0] s;
    s = signed'(mag);
    return neg ? -s : s;
  endfunction

  logic             req;
  logic             is_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             dz_in, ovf_in;
  logic             early_in;
  logic [WIDTH-1:0] early_res;

  assign req       = i_div_en & i_funct3[2];
  assign is_signed = ~i_funct3[0];
  assign a_neg     = is_signed & i_in_a[WIDTH-1];
  assign b_neg     = is_signed & i_in_b[WIDTH-1];
  assign mag_a     = magnitude(i_in_a, is_signed);
  assign mag_b     = magnitude(i_in_b, is_signed);
  assign dz_in     = (i_in_b == '0);
  assign ovf_in    = is_signed && (i_in_a == MIN_NEG) && (&i_in_b);

`ifdef DIVIDER_EARLY_OUT_EN
  assign early_in  = dz_in || ovf_in || (mag_a < mag_b);
  always_comb begin
    if (dz_in)       early_res = i_funct3[1] ? i_in_a : '1;
    else if (ovf_in) early_res = i_funct3[1] ? '0 : MIN_NEG;
    else             early_res = i_funct3[1] ? i_in_a : '0;
  end
`else
  assign early_in  = 1'b0;
  assign early_res = '0;
`endif

  // Partial remainder keeps one extra bit so divisors above 2^(WIDTH-1) still compare correctly.
  logic [WIDTH:0]   partial;
  logic             ge;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign partial = {rem_q, quo_q[WIDTH-1]};
  assign ge      = (partial >= {1'b0, div_q});
  assign q_fix   = sign_fix(quo_q, neg_quo_q);
  assign r_fix   = sign_fix(rem_q, neg_rem_q);

  always_comb begin
    state_d   = state_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    div_d     = div_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    rem_sel_d = rem_sel_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    o_busy    = 1'b0;
    unique case (state_q)
      IDLE: begin
        o_busy = req & i_rst_n;
        if (req) begin
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          rem_sel_d = i_funct3[1];
          dz_d      = dz_in;
          ovf_d     = ovf_in;
          if (early_in) begin
            res_d   = early_res;
            state_d = DONE;
          end else begin
            quo_d   = mag_a;
            rem_d   = '0;
            div_d   = mag_b;
            cnt_d   = CNT_W'(WIDTH-1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        o_busy = 1'b1;
        rem_d  = ge ? WIDTH'(partial - {1'b0, div_q}) : partial[WIDTH-1:0];
        quo_d  = {quo_q[WIDTH-2:0], ge};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        o_busy = 1'b1;
        if (dz_q)       res_d = rem_sel_q ? r_fix : '1;
        else if (ovf_q) res_d = rem_sel_q ? '0 : MIN_NEG;
        else            res_d = rem_sel_q ? r_fix : q_fix;
        state_d = DONE;
      end
      DONE: begin
        // A still-asserted request here is the same instruction; only leaving returns to IDLE.
        if (i_pipe_adv || !req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk_n or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      quo_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_sel_q <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      rem_sel_q <= rem_sel_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_result = res_q;

endmodule

// File: tb/tb_divider.sv
// tb_divider: directed-vector bench for the divider (both DIVIDER_EARLY_OUT_EN builds).
module tb_divider;
  localparam int W = 32;
`ifdef DIVIDER_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [2:0]   funct3 = 3'b000;
  logic         div_en = 1'b0;
  logic         pipe_adv = 1'b0;
  logic [W-1:0] result;
  logic         busy;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  always #5 clk = ~clk;

  divider #(.WIDTH(W)) dut (
    .i_clk_n   (clk),
    .i_rst_n   (rst_n),
    .i_in_a    (in_a),
    .i_in_b    (in_b),
    .i_funct3  (funct3),
    .i_div_en  (div_en),
    .i_pipe_adv(pipe_adv),
    .o_result  (result),
    .o_busy    (busy)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    funct3 = f3;
    in_a   = a;
    in_b   = b;
    div_en = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int exp_n, input logic [W-1:0] exp_res);
    int n;
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, " busy-cycles"}, W'(n), W'(exp_n));
    check({tag, " result"}, result, exp_res);
  endtask

  task automatic drop_req();
    @(posedge clk); #1;
    div_en = 1'b0;
    @(posedge clk);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_res, input bit eo);
    int exp_n;
    exp_n = (eo && EARLY) ? 1 : 34;
    start_op(f3, a, b);
    wait_done(tag, exp_n, exp_res);
    drop_req();
  endtask

  initial begin
    #2;
    check("reset busy", W'(busy), W'(1'b0));
    check("reset result", result, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("idle busy", W'(busy), W'(1'b0));

    run_op("DIVU 100/7",       F_DIVU, 32'd100,      32'd7,        32'h0000000E, 1'b0);
    run_op("REMU 100/7",       F_REMU, 32'd100,      32'd7,        32'h00000002, 1'b0);
    run_op("DIV -7/2",         F_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);
    run_op("REM -7/2",         F_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0);
    run_op("REM 7/-2",         F_REM,  32'd7,        32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("DIVU big divisor", F_DIVU, 32'hFFFFFFFF, 32'h80000001, 32'h00000001, 1'b0);
    run_op("REMU big divisor", F_REMU, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 1'b0);
    run_op("DIVU by zero",     F_DIVU, 32'h12345678, 32'h0,        32'hFFFFFFFF, 1'b1);
    run_op("DIV by zero",      F_DIV,  32'h12345678, 32'h0,        32'hFFFFFFFF, 1'b1);
    run_op("REMU by zero",     F_REMU, 32'h12345678, 32'h0,        32'h12345678, 1'b1);
    run_op("REM by zero",      F_REM,  32'h12345678, 32'h0,        32'h12345678, 1'b1);
    run_op("DIV -7 by zero",   F_DIV,  32'hFFFFFFF9, 32'h0,        32'hFFFFFFFF, 1'b1);
    run_op("REM -7 by zero",   F_REM,  32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 1'b1);
    run_op("DIV overflow",     F_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    run_op("REM overflow",     F_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    run_op("DIVU 3/10",        F_DIVU, 32'd3,        32'd10,       32'h00000000, 1'b1);
    run_op("REMU 3/10",        F_REMU, 32'd3,        32'd10,       32'h00000003, 1'b1);
    run_op("DIV -3/10",        F_DIV,  32'hFFFFFFFD, 32'd10,       32'h00000000, 1'b1);
    run_op("REM -3/10",        F_REM,  32'hFFFFFFFD, 32'd10,       32'hFFFFFFFD, 1'b1);

    // Request held past DONE must not restart the unit.
    start_op(F_DIVU, 32'd100, 32'd7);
    wait_done("hold DIVU 100/7", 34, 32'h0000000E);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("hold busy c%0d", i), W'(busy), W'(1'b0));
      check($sformatf("hold result c%0d", i), result, 32'h0000000E);
    end
    @(posedge clk); #1;
    div_en   = 1'b0;
    pipe_adv = 1'b1;
    @(posedge clk); #1;
    pipe_adv = 1'b0;
    run_op("DIVU 9/3 after adv", F_DIVU, 32'd9, 32'd3, 32'h00000003, 1'b0);

    // Asynchronous reset in the middle of CALC.
    start_op(F_DIVU, 32'd100, 32'd7);
    repeat (15) @(posedge clk);
    #1;
    check("pre-reset busy", W'(busy), W'(1'b1));
    check("pre-reset result", result, 32'h00000003);
    rst_n  = 1'b0;
    in_a   = 32'hFFFFFFFF;
    in_b   = 32'h00000010;
    #1;
    check("mid-reset busy", W'(busy), W'(1'b0));
    check("mid-reset result", result, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_done("DIVU FFFFFFFF/10 after reset", 34, 32'h0FFFFFFF);
    drop_req();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
